// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
// Round sequencer for the snake game: game-state FSM (idle/play/pause/over),
// move-tick timer, step handshake with the snake datapath, score tally and
// food placement by scanning the snake body memory for a free cell.
// Optional feature macro: SNAKE_SPEEDUP_EN. When defined, the move period
// shrinks by TICK_STEP per food eaten, down to TICK_MIN. Otherwise the
// period is fixed at TICK_INIT.
module snake_game_ctrl #(
   parameter int GRID_W    = 40,
   parameter int GRID_H    = 30,
   parameter int TICK_INIT = 5_000_000,
   parameter int TICK_MIN  = 1_000_000,
   parameter int TICK_STEP = 250_000,
   parameter int RETRY_MAX = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        key_valid_i,
   input  logic [7:0]  key_code_i,
   input  logic [15:0] random_num_i,
   output logic        step_req_o,
   input  logic        step_ack_i,
   input  logic [1:0]  step_result_i,
   input  logic [7:0]  snake_length_i,
   output logic [7:0]  body_rd_addr_o,
   input  logic [5:0]  body_rd_x_i,
   input  logic [5:0]  body_rd_y_i,
   output logic        game_reset_o,
   output logic [5:0]  food_x_o,
   output logic [5:0]  food_y_o,
   output logic        food_valid_o,
   output logic [1:0]  state_o,
   output logic [15:0] score_o,
   output logic [23:0] tick_period_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } game_state_e;

   // Sub-phases of PLAY: running the timer, waiting for the datapath,
   // one settling cycle after game_reset, and the two placement phases.
   typedef enum logic [2:0] {
      PH_RUN,
      PH_WAIT,
      PH_START,
      PH_GEN,
      PH_SCAN
   } phase_e;

   localparam logic [5:0]  X_MOD       = 6'(GRID_W - 2);
   localparam logic [5:0]  Y_MOD       = 6'(GRID_H - 2);
   localparam logic [5:0]  X_LAST      = 6'(GRID_W - 2);
   localparam logic [5:0]  Y_LAST      = 6'(GRID_H - 2);
   localparam logic [7:0]  RETRY_LIM   = 8'(RETRY_MAX);
   localparam logic [23:0] PERIOD_INIT = 24'(TICK_INIT);

   game_state_e state_q;
   phase_e      phase_q;
   logic        step_req_q;
   logic        game_reset_q;
   logic        food_valid_q;
   logic [5:0]  food_x_q;
   logic [5:0]  food_y_q;
   logic [5:0]  cand_x_q;
   logic [5:0]  cand_y_q;
   logic [15:0] score_q;
   logic [23:0] tick_cnt_q;
   logic [7:0]  body_rd_addr_q;
   logic [7:0]  retry_q;
   logic        cmp_valid_q;
   logic        cmp_last_q;

   logic        space_key;
   logic        pause_key;
   logic        start_game;
   logic        food_eaten;
   logic        body_hit;
   logic        scan_last;
   logic        tick_hit;
   logic [23:0] period_cur;
   logic [5:0]  rand_x;
   logic [5:0]  rand_y;
   logic [5:0]  raster_x;
   logic [5:0]  raster_y;
   logic [5:0]  cand_x_d;
   logic [5:0]  cand_y_d;
   logic        sig_unused;

   // Only the 6-bit x and y fields of the random word feed the candidate.
   assign sig_unused = ^{random_num_i[15:14], random_num_i[7:6]};

   // Key decode and the two events that also drive the period register.
   always_comb begin
      space_key  = key_valid_i && (key_code_i == 8'h29);
      pause_key  = key_valid_i && (key_code_i == 8'h4D);
      start_game = (state_q == ST_IDLE) && space_key;
      food_eaten = (state_q == ST_PLAY) && (phase_q == PH_WAIT) &&
                   step_ack_i && (step_result_i == 2'b01);
   end

   // Food candidate: a random interior cell, or once the retry budget is
   // spent, the raster successor of the last rejected candidate so that
   // placement always terminates even on a crowded board.
   always_comb begin
      rand_x = 6'd1 + (random_num_i[5:0] % X_MOD);
      rand_y = 6'd1 + (random_num_i[13:8] % Y_MOD);
      if (cand_x_q >= X_LAST) begin
         raster_x = 6'd1;
         raster_y = (cand_y_q >= Y_LAST) ? 6'd1 : cand_y_q + 6'd1;
      end else begin
         raster_x = cand_x_q + 6'd1;
         raster_y = cand_y_q;
      end
      if (retry_q >= RETRY_LIM) begin
         cand_x_d = raster_x;
         cand_y_d = raster_y;
      end else begin
         cand_x_d = rand_x;
         cand_y_d = rand_y;
      end
   end

   // Scan compare: body data returned this cycle belongs to the address
   // issued last cycle; scan_last marks the final body index being issued.
   always_comb begin
      body_hit  = cmp_valid_q && (body_rd_x_i == cand_x_q) && (body_rd_y_i == cand_y_q);
      scan_last = ({1'b0, body_rd_addr_q} + 9'd1) >= {1'b0, snake_length_i};
      tick_hit  = (tick_cnt_q == (period_cur - 24'd1));
   end

`ifdef SNAKE_SPEEDUP_EN
   localparam logic [23:0] PERIOD_MIN  = 24'(TICK_MIN);
   localparam logic [23:0] PERIOD_STEP = 24'(TICK_STEP);

   logic [23:0] tick_period_q;
   logic [23:0] tick_period_d;

   // Next period after a food: one step faster, clamped at the minimum.
   always_comb begin
      if (tick_period_q >= (PERIOD_MIN + PERIOD_STEP)) begin
         tick_period_d = tick_period_q - PERIOD_STEP;
      end else begin
         tick_period_d = PERIOD_MIN;
      end
   end

   // Move period register: restored on every new game, shortened per food.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_period_q <= PERIOD_INIT;
      end else if (start_game) begin
         tick_period_q <= PERIOD_INIT;
      end else if (food_eaten) begin
         tick_period_q <= tick_period_d;
      end
   end

   assign period_cur = tick_period_q;
`else
   localparam logic [23:0] unused_speed_cfg = 24'(TICK_MIN) ^ 24'(TICK_STEP);

   assign period_cur = PERIOD_INIT;
`endif

   // Game sequencer: state, PLAY sub-phase, tick timer, step handshake,
   // score and the food placement scan, all registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         phase_q        <= PH_RUN;
         step_req_q     <= 1'b0;
         game_reset_q   <= 1'b0;
         food_valid_q   <= 1'b0;
         food_x_q       <= 6'd0;
         food_y_q       <= 6'd0;
         cand_x_q       <= 6'd0;
         cand_y_q       <= 6'd0;
         score_q        <= 16'd0;
         tick_cnt_q     <= 24'd0;
         body_rd_addr_q <= 8'd0;
         retry_q        <= 8'd0;
         cmp_valid_q    <= 1'b0;
         cmp_last_q     <= 1'b0;
      end else begin
         step_req_q   <= 1'b0;
         game_reset_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_game) begin
                  state_q      <= ST_PLAY;
                  phase_q      <= PH_START;
                  game_reset_q <= 1'b1;
                  score_q      <= 16'd0;
                  food_valid_q <= 1'b0;
                  tick_cnt_q   <= 24'd0;
                  retry_q      <= 8'd0;
               end
            end
            ST_PLAY: begin
               case (phase_q)
                  PH_START: begin
                     phase_q <= PH_GEN;
                  end
                  PH_GEN: begin
                     cand_x_q       <= cand_x_d;
                     cand_y_q       <= cand_y_d;
                     body_rd_addr_q <= 8'd0;
                     cmp_valid_q    <= 1'b0;
                     cmp_last_q     <= 1'b0;
                     phase_q        <= PH_SCAN;
                  end
                  PH_SCAN: begin
                     if (body_hit) begin
                        phase_q        <= PH_GEN;
                        body_rd_addr_q <= 8'd0;
                        cmp_valid_q    <= 1'b0;
                        cmp_last_q     <= 1'b0;
                        if (retry_q < RETRY_LIM) begin
                           retry_q <= retry_q + 8'd1;
                        end
                     end else if (cmp_valid_q && cmp_last_q) begin
                        food_x_q       <= cand_x_q;
                        food_y_q       <= cand_y_q;
                        food_valid_q   <= 1'b1;
                        body_rd_addr_q <= 8'd0;
                        cmp_valid_q    <= 1'b0;
                        cmp_last_q     <= 1'b0;
                        tick_cnt_q     <= 24'd0;
                        phase_q        <= PH_RUN;
                     end else begin
                        cmp_valid_q <= 1'b1;
                        cmp_last_q  <= scan_last;
                        if (!scan_last) begin
                           body_rd_addr_q <= body_rd_addr_q + 8'd1;
                        end
                     end
                  end
                  PH_RUN: begin
                     if (pause_key) begin
                        state_q <= ST_PAUSE;
                     end else if (tick_hit) begin
                        step_req_q <= 1'b1;
                        phase_q    <= PH_WAIT;
                     end else begin
                        tick_cnt_q <= tick_cnt_q + 24'd1;
                     end
                  end
                  PH_WAIT: begin
                     if (step_ack_i) begin
                        tick_cnt_q <= 24'd0;
                        case (step_result_i)
                           2'b01: begin
                              if (score_q != 16'hFFFF) begin
                                 score_q <= score_q + 16'd1;
                              end
                              food_valid_q <= 1'b0;
                              retry_q      <= 8'd0;
                              phase_q      <= PH_GEN;
                           end
                           2'b10: begin
                              state_q <= ST_OVER;
                              phase_q <= PH_RUN;
                           end
                           default: begin
                              phase_q <= PH_RUN;
                           end
                        endcase
                     end
                  end
                  default: begin
                     phase_q <= PH_RUN;
                  end
               endcase
            end
            ST_PAUSE: begin
               if (pause_key) begin
                  state_q <= ST_PLAY;
               end
            end
            ST_OVER: begin
               if (space_key) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign step_req_o     = step_req_q;
   assign game_reset_o   = game_reset_q;
   assign body_rd_addr_o = body_rd_addr_q;
   assign food_x_o       = food_x_q;
   assign food_y_o       = food_y_q;
   assign food_valid_o   = food_valid_q;
   assign state_o        = state_q;
   assign score_o        = score_q;
   assign tick_period_o  = period_cur;

endmodule
